if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage directly downstream of the PC register. Each cycle it turns `curr_pc` into an instruction-memory request, tracks outstanding requests, buffers returned words with their PCs in an in-order queue, and presents them to decode with a valid/ready handshake. It drives `pc_hold` so the next-PC mux recirculates `curr_pc` while a fetch cannot issue. On `redirect` it flushes wrong-path work.

## Interface
- `CPU_WIDTH`, 32, PC/address width.
- `IQ_DEPTH`, 4, instruction-queue entries; power of two, ≥2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `curr_pc`  in  CPU_WIDTH  PC register output; word-aligned.
- `pc_hold`  out  1  next-PC mux must select `curr_pc` (no advance).
- `redirect`  in  1  taken branch/jump this cycle; PC loads the target at the next edge.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  CPU_WIDTH  fetch address; equals `curr_pc`.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response word valid; in order; no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  head entry valid to decode.
- `inst_data`  out  32  head instruction.
- `inst_pc`  out  CPU_WIDTH  PC of head instruction.
- `inst_ready`  in  1  decode accepts head.

## Operation
- State machine:
  - BOOT is entered on reset. The PC resets to -4, which is never fetched. In BOOT: `imem_req_valid`=0 and `pc_hold`=0. Always moves to RUN at the next edge, with the PC now 0.
  - RUN is normal operation.
- Queue: circular buffer of `IQ_DEPTH` entries, each {pc, data, filled}.
  - Registered counters: `alloc` = entries allocated, 0..IQ_DEPTH; `discard` = wrong-path responses still expected, 0..IQ_DEPTH.
- Issue, in RUN:
  - `imem_req_valid` = !redirect && (alloc + discard < IQ_DEPTH). Uses registered counts only; no same-cycle pop bypass.
  - On accept (`imem_req_valid` && `imem_req_ready`): allocate the tail entry with pc=`curr_pc`, filled=0.
- `pc_hold`:
  - RUN: `pc_hold` = !redirect && !(imem_req_valid && imem_req_ready).
  - `redirect` always forces `pc_hold`=0.
- Response:
  - If `discard`>0, decrement `discard` and drop the word.
  - Otherwise write data into the oldest unfilled entry and set filled.
  - A response with no outstanding request and `discard`=0 is ignored.
- Output: `inst_valid` = head filled && !redirect. `inst_data` and `inst_pc` come from the head entry. Pop on `inst_valid` && `inst_ready`.
- Redirect, at the next edge:
  - `discard` += number of allocated-but-unfilled entries. A response arriving in the same cycle is counted against these first.
  - All entries are invalidated, `alloc`=0, pointers reset.
  - In BOOT, `redirect` is ignored.
- `alloc` accounting: +1 per accept, −1 per pop, independently in the same cycle.

## Timing
- Reset values: `imem_req_valid`=0, `pc_hold`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0. State=BOOT; counters and pointers 0.
- Reset mid-operation clears all state immediately; pending responses are lost.
- Request accepted at edge N: the PC advances at edge N.
- Response in cycle M is written at edge M; `inst_valid` is high from cycle M+1. Minimum fetch-to-decode latency is 2 cycles with a 1-cycle memory.
- With a 1-cycle memory, IQ_DEPTH ≥ 4 sustains 1 instruction/cycle.
- Queue full (alloc+discard = IQ_DEPTH): no request, `pc_hold`=1.
- Empty: `inst_valid`=0.
- Pointer wrap is modulo IQ_DEPTH.

## Test plan
- Reset release -> cycle 0: req_valid=0, pc_hold=0. Cycle 1: req_valid=1, addr=0x0.
- 1-cycle memory, ready always 1, data=addr^0xA5A5A5A5 -> inst_pc 0x0, 0x4, 0x8… one per cycle, data matching.
- inst_ready=0 for 10 cycles -> after 4 accepts req_valid=0, pc_hold=1, curr_pc held at 0x10. Release -> in-order delivery resumes with no gap or duplicate.
- imem_req_ready=0 for 3 cycles -> pc_hold=1, addr stable, no allocation. Fetch resumes at the same PC.
- 3-cycle memory, redirect to 0x100 with 2 outstanding -> next 2 responses dropped. First inst_pc after that is 0x100.
- Async rst_n low mid-stream with inst_valid=1 -> inst_valid=0 and req_valid=0 without waiting for a clock edge. After release, the BOOT sequence repeats.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Fetch is the master; the memory side is the slave.
interface if_fetch_if #(
   parameter int W = 32
);
   logic          req_valid;
   logic [W-1:0]  req_addr;
   logic          req_ready;
   logic          rsp_valid;
   logic [31:0]   rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/if_fetch.sv
// Fetch stage: issues imem requests from curr_pc, buffers in-order
// responses in a small queue and hands them to decode.
module if_fetch #(
   parameter int CPU_WIDTH = 32,
   parameter int IQ_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CPU_WIDTH-1:0] curr_pc,
   output logic                 pc_hold,
   input  logic                 redirect,
   if_fetch_if.master           imem,
   output logic                 inst_valid,
   output logic [31:0]          inst_data,
   output logic [CPU_WIDTH-1:0] inst_pc,
   input  logic                 inst_ready
);

   localparam int AW = $clog2(IQ_DEPTH);
   localparam int CW = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t DEPTH = cnt_t'(IQ_DEPTH);
   localparam ptr_t ONE_P = ptr_t'(1);

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t state, state_n;

   logic [CPU_WIDTH-1:0] pc_q   [IQ_DEPTH];
   logic [31:0]          data_q [IQ_DEPTH];
   logic [IQ_DEPTH-1:0]  fill_q;

   ptr_t head, tail, fptr;
   cnt_t alloc, discard, pend;

   logic       run;
   logic       flush;
   logic       accept;
   logic       pop;
   logic       drop;
   logic       fill;
   logic [CW:0] used;

   always_comb begin
      state_n        = state;
      run            = 1'b0;
      flush          = 1'b0;
      used           = '0;
      imem.req_valid = 1'b0;
      imem.req_addr  = curr_pc;
      accept         = 1'b0;
      pc_hold        = 1'b0;
      inst_valid     = 1'b0;
      pop            = 1'b0;
      drop           = 1'b0;
      fill           = 1'b0;
      inst_data      = data_q[head];
      inst_pc        = pc_q[head];

      unique case (state)
         BOOT: state_n = RUN;
         RUN:  state_n = RUN;
      endcase

      run   = (state == RUN);
      flush = run && redirect;
      // Wrong-path words still in flight occupy queue credit too.
      used  = {1'b0, alloc} + {1'b0, discard};

      imem.req_valid = run && !redirect && (used < {1'b0, DEPTH});
      accept         = imem.req_valid && imem.req_ready;
      pc_hold        = run && !redirect && !accept;

      inst_valid = run && !redirect && fill_q[head];
      pop        = inst_valid && inst_ready;

      drop = run && imem.rsp_valid && (discard != '0);
      fill = run && imem.rsp_valid && (discard == '0) && (pend != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= BOOT;
         head    <= '0;
         tail    <= '0;
         fptr    <= '0;
         alloc   <= '0;
         discard <= '0;
         pend    <= '0;
         fill_q  <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state <= state_n;
         if (flush) begin
            head    <= '0;
            tail    <= '0;
            fptr    <= '0;
            alloc   <= '0;
            pend    <= '0;
            fill_q  <= '0;
            // Same-cycle response retires one unfilled slot first.
            discard <= discard + pend
                       - cnt_t'(drop) - cnt_t'(fill);
         end else begin
            if (accept) begin
               pc_q[tail]   <= curr_pc;
               fill_q[tail] <= 1'b0;
               tail         <= tail + ONE_P;
            end
            if (fill) begin
               data_q[fptr] <= imem.rsp_data;
               fill_q[fptr] <= 1'b1;
               fptr         <= fptr + ONE_P;
            end
            if (pop) begin
               fill_q[head] <= 1'b0;
               head         <= head + ONE_P;
            end
            alloc   <= alloc + cnt_t'(accept) - cnt_t'(pop);
            pend    <= pend + cnt_t'(accept) - cnt_t'(fill);
            discard <= discard - cnt_t'(drop);
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: PC register and imem models around the DUT,
// scoreboard of accepted right-path PCs checked at decode.
module tb_if_fetch;

   localparam int          W = 32;
   localparam logic [31:0] K = 32'hA5A5_A5A5;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  curr_pc;
   logic [W-1:0]  target;
   logic          pc_hold;
   logic          redirect;
   logic          inst_valid;
   logic          inst_ready;
   logic [31:0]   inst_data;
   logic [W-1:0]  inst_pc;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;
   int npop     = 0;

   mreq_t       mq[$];
   logic [31:0] exp_q[$];

   if_fetch_if #(.W(W)) bus ();

   if_fetch #(
      .CPU_WIDTH(W),
      .IQ_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .curr_pc   (curr_pc),
      .pc_hold   (pc_hold),
      .redirect  (redirect),
      .imem      (bus),
      .inst_valid(inst_valid),
      .inst_data (inst_data),
      .inst_pc   (inst_pc),
      .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   // PC register with next-PC mux
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        curr_pc <= 32'hFFFF_FFFC;
      else if (redirect) curr_pc <= target;
      else if (!pc_hold) curr_pc <= curr_pc + 32'd4;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Decode-side monitor: every delivered word must be the next
   // right-path fetch, carrying the word memory holds at that PC.
   always @(negedge clk) begin
      if (rst_n && inst_valid && inst_ready) begin
         npop++;
         if (exp_q.size() == 0) begin
            chk("unexpected_inst", inst_pc, 32'hxxxx_xxxx);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e);
            chk("inst_data", inst_data, e ^ K);
         end
      end
   end

   task automatic half();
      @(negedge clk);
      if (rst_n && bus.req_valid && bus.req_ready) begin
         mreq_t m;
         m.due  = cyc + lat;
         m.addr = bus.req_addr;
         mq.push_back(m);
         exp_q.push_back(curr_pc);
      end
      if (rst_n && redirect) exp_q.delete();
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mreq_t m;
         m = mq.pop_front();
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = m.addr ^ K;
      end else begin
         bus.rsp_valid = 1'b0;
         bus.rsp_data  = $urandom;
      end
   endtask

   task automatic do_reset(input int l);
      rst_n         = 1'b0;
      redirect      = 1'b0;
      target        = '0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      inst_ready    = 1'b0;
      mq.delete();
      exp_q.delete();
      lat = l;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic boot_checks();
      half();
      chk("boot_req_valid", 32'(bus.req_valid), 32'd0);
      chk("boot_pc_hold", 32'(pc_hold), 32'd0);
      next();
      half();
      chk("run_req_valid", 32'(bus.req_valid), 32'd1);
      chk("run_req_addr", bus.req_addr, 32'h0);
      next();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n0;
      logic [31:0] held;
      bit          found;

      redirect      = 1'b0;
      target        = '0;
      inst_ready    = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;

      do_reset(1);
      #1;
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);

      // decode stall fills the queue
      bus.req_ready = 1'b1;
      boot_checks();
      while (cyc < 10) begin
         half();
         next();
      end
      half();
      chk("full_req_valid", 32'(bus.req_valid), 32'd0);
      chk("full_pc_hold", 32'(pc_hold), 32'd1);
      chk("full_curr_pc", curr_pc, 32'h10);
      next();
      inst_ready = 1'b1;
      while (cyc < 30) begin
         half();
         next();
      end
      n0 = npop;
      while (cyc < 50) begin
         half();
         next();
      end
      chk("stream_rate", 32'(npop - n0), 32'd20);

      // memory not ready
      held          = curr_pc;
      bus.req_ready = 1'b0;
      repeat (3) begin
         half();
         chk("stall_pc_hold", 32'(pc_hold), 32'd1);
         chk("stall_addr", bus.req_addr, held);
         next();
      end
      bus.req_ready = 1'b1;
      half();
      chk("resume_req_valid", 32'(bus.req_valid), 32'd1);
      chk("resume_addr", bus.req_addr, held);
      next();
      repeat (10) begin
         half();
         next();
      end

      // redirect with two requests in flight
      do_reset(3);
      bus.req_ready = 1'b1;
      inst_ready    = 1'b1;
      boot_checks();
      half();
      next();
      redirect = 1'b1;
      target   = 32'h100;
      half();
      chk("redir_pc_hold", 32'(pc_hold), 32'd0);
      chk("redir_req_valid", 32'(bus.req_valid), 32'd0);
      next();
      redirect = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         half();
         if (inst_valid) begin
            found = 1'b1;
            chk("redir_first_pc", inst_pc, 32'h100);
         end else begin
            next();
         end
      end
      if (!found) chk("redir_timeout", 32'd0, 32'd1);

      // asynchronous reset while a word is on offer
      rst_n = 1'b0;
      #1;
      chk("async_inst_valid", 32'(inst_valid), 32'd0);
      chk("async_req_valid", 32'(bus.req_valid), 32'd0);
      chk("async_pc_hold", 32'(pc_hold), 32'd0);
      do_reset(1);
      bus.req_ready = 1'b1;
      inst_ready    = 1'b1;
      boot_checks();
      repeat (10) begin
         half();
         next();
      end

      // randomized traffic
      n0 = npop;
      for (int s = 0; s < 4; s++) begin
         do_reset(int'($urandom_range(1, 3)));
         bus.req_ready = 1'b1;
         boot_checks();
         repeat (300) begin
            redirect      = ($urandom_range(0, 15) == 0);
            target        = 32'($urandom_range(0, 1023)) << 2;
            bus.req_ready = ($urandom_range(0, 3) != 0);
            inst_ready    = ($urandom_range(0, 3) != 0);
            half();
            if (bus.req_valid)
               chk("addr_eq_pc", bus.req_addr, curr_pc);
            next();
         end
         redirect = 1'b0;
      end
      chk("random_progress", 32'(npop - n0 > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
